program_loader: RTL

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 108 ++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Serial program loader: receives start/8-data/stop framed bytes on dato and
// writes each good byte into program memory at consecutive addresses.
module program_loader (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_addr,
  input  logic [11:0] addr_in,
  input  logic [11:0] len_in,
  input  logic        start,
  input  logic        dato,
  input  logic        bit_valid,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_we,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [11:0] byte_count
);

  typedef enum logic [2:0] {
    IDLE, WAIT_START, DATA, STOP, WRITE, DONE, ERROR
  } state_t;

  state_t      state, state_next;
  logic [11:0] addr_reg;
  logic [11:0] len_reg;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_reg;
  logic [11:0] count_inc;
  logic        cmd_ok;

  assign count_inc = byte_count + 12'd1;
  // Commands are only accepted while parked, i.e. whenever busy is low.
  assign cmd_ok    = (state == IDLE) || (state == ERROR);

  // Decoded straight from the state register so that an asynchronous reset
  // drops the strobes at once, without waiting for a clock edge.
  assign mem_we = (state == WRITE);
  assign done   = (state == DONE);
  assign busy   = !cmd_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, ERROR: if (start) state_next = (len_in == 12'd0) ? DONE : WAIT_START;
      WAIT_START:  if (bit_valid && !dato) state_next = DATA;
      DATA:        if (bit_valid && bit_idx == 3'd7) state_next = STOP;
      STOP:        if (bit_valid) state_next = dato ? WRITE : ERROR;
      WRITE:       state_next = (count_inc == len_reg) ? DONE : WAIT_START;
      DONE:        state_next = IDLE;
      default:     state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_reg   <= 12'h000;
      len_reg    <= 12'd0;
      bit_idx    <= 3'd0;
      shift_reg  <= 8'h00;
      mem_addr   <= 12'h000;
      mem_data   <= 8'h00;
      error      <= 1'b0;
      byte_count <= 12'd0;
    end else begin
      case (state)
        IDLE, ERROR: begin
          // load_addr and start may coincide; the session then uses addr_in.
          if (load_addr) addr_reg <= addr_in;
          if (start) begin
            len_reg    <= len_in;
            byte_count <= 12'd0;
            error      <= 1'b0;
          end
        end
        WAIT_START: if (bit_valid && !dato) bit_idx <= 3'd0;
        DATA: begin
          if (bit_valid) begin
            shift_reg[bit_idx] <= dato;
            bit_idx            <= bit_idx + 3'd1;
          end
        end
        STOP: begin
          if (bit_valid) begin
            if (dato) begin
              mem_addr <= addr_reg;
              mem_data <= shift_reg;
            end else begin
              error <= 1'b1;
            end
          end
        end
        WRITE: begin
          addr_reg   <= addr_reg + 12'd1;
          byte_count <= count_inc;
        end
        default: ;
      endcase
    end
  end

endmodule
